// File: rtl/eth_tx_framer.sv
// GMII transmit framer: wraps a streamed frame body with preamble/SFD, zero pad,
// CRC-32 FCS and inter-frame gap; flags truncated and underrun frames.
module eth_tx_framer #(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1514,
    parameter int unsigned IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic        o_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_en,
    output logic        o_tx_er,
    output logic        o_busy,
    output logic        o_trunc,
    output logic        o_underrun,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned IFG_W = $clog2(IFG_LEN + 1);

    localparam logic [10:0]      MIN_LEN_C  = 11'(MIN_LEN);
    localparam logic [10:0]      MAX_LEN_C  = 11'(MAX_LEN);
    localparam logic [IFG_W-1:0] IFG_LAST_C = IFG_W'(IFG_LEN - 1);
    localparam logic [IFG_W-1:0] IFG_FULL_C = IFG_W'(IFG_LEN);
    localparam logic [IFG_W-1:0] IFG_ONE_C  = IFG_W'(1);
    localparam logic [31:0]      CRC_POLY_C = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_INIT_C = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_SFD   = 3'd2,
        ST_DATA  = 3'd3,
        ST_PAD   = 3'd4,
        ST_FCS   = 3'd5,
        ST_IFG   = 3'd6,
        ST_DRAIN = 3'd7
    } state_e;

    // Reflected CRC-32 update, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if ((c[0] ^ data[i]) == 1'b1) begin
                c = (c >> 1) ^ CRC_POLY_C;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_e            state_q, state_d;
    logic [10:0]       byte_cnt_q, byte_cnt_d;
    logic [2:0]        pre_cnt_q, pre_cnt_d;
    logic [1:0]        fcs_idx_q, fcs_idx_d;
    logic [IFG_W-1:0]  ifg_cnt_q, ifg_cnt_d;
    logic [31:0]       crc_q, crc_d;
    logic              trunc_flag_q, trunc_flag_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              tx_er_q, tx_er_d;
    logic              trunc_q, trunc_d;
    logic              underrun_q, underrun_d;

    logic [10:0]       cnt_inc_s;
    logic [31:0]       crc_data_s;
    logic [31:0]       crc_pad_s;
    logic [31:0]       fcs_s;
    logic [7:0]        fcs_byte_s;

    assign cnt_inc_s  = byte_cnt_q + 11'd1;
    assign crc_data_s = crc32_byte(crc_q, i_data);
    assign crc_pad_s  = crc32_byte(crc_q, 8'h00);
    assign fcs_s      = ~crc_q;

    // FCS byte selector, least significant byte on the wire first.
    always_comb begin
        fcs_byte_s = 8'h00;
        case (fcs_idx_q)
            2'd0:    fcs_byte_s = fcs_s[7:0];
            2'd1:    fcs_byte_s = fcs_s[15:8];
            2'd2:    fcs_byte_s = fcs_s[23:16];
            default: fcs_byte_s = fcs_s[31:24];
        endcase
    end

    // Next-state and next-output decode; GMII outputs lead the state by one cycle.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        pre_cnt_d    = pre_cnt_q;
        fcs_idx_d    = fcs_idx_q;
        ifg_cnt_d    = ifg_cnt_q;
        crc_d        = crc_q;
        trunc_flag_d = trunc_flag_q;
        frame_cnt_d  = frame_cnt_q;
        tx_data_d    = 8'h00;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        trunc_d      = 1'b0;
        underrun_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                crc_d        = CRC_INIT_C;
                byte_cnt_d   = 11'd0;
                pre_cnt_d    = 3'd0;
                fcs_idx_d    = 2'd0;
                ifg_cnt_d    = '0;
                trunc_flag_d = 1'b0;
                if (i_valid) begin
                    state_d   = ST_PRE;
                    tx_data_d = 8'h55;
                    tx_en_d   = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_PRE: begin
                // The IDLE exit already launched the first preamble byte.
                tx_data_d = 8'h55;
                tx_en_d   = 1'b1;
                if (pre_cnt_q == 3'd5) begin
                    state_d = ST_SFD;
                end else begin
                    pre_cnt_d = pre_cnt_q + 3'd1;
                end
            end

            ST_SFD: begin
                tx_data_d = 8'hD5;
                tx_en_d   = 1'b1;
                state_d   = ST_DATA;
            end

            ST_DATA: begin
                if (i_valid) begin
                    tx_data_d  = i_data;
                    tx_en_d    = 1'b1;
                    byte_cnt_d = cnt_inc_s;
                    crc_d      = crc_data_s;
                    if (i_last) begin
                        if (cnt_inc_s < MIN_LEN_C) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                        end
                    end else if (cnt_inc_s == MAX_LEN_C) begin
                        state_d      = ST_FCS;
                        trunc_flag_d = 1'b1;
                        trunc_d      = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    tx_en_d    = 1'b1;
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    ifg_cnt_d  = '0;
                    state_d    = ST_DRAIN;
                end
            end

            ST_PAD: begin
                tx_en_d    = 1'b1;
                byte_cnt_d = cnt_inc_s;
                crc_d      = crc_pad_s;
                if (cnt_inc_s == MIN_LEN_C) begin
                    state_d = ST_FCS;
                end else begin
                    state_d = ST_PAD;
                end
            end

            ST_FCS: begin
                tx_data_d = fcs_byte_s;
                tx_en_d   = 1'b1;
                if (fcs_idx_q == 2'd3) begin
                    state_d   = ST_IFG;
                    ifg_cnt_d = '0;
                    if (trunc_flag_q) begin
                        frame_cnt_d = frame_cnt_q;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end else begin
                    fcs_idx_d = fcs_idx_q + 2'd1;
                end
            end

            ST_IFG: begin
                if (ifg_cnt_q == IFG_LAST_C) begin
                    if (trunc_flag_q) begin
                        state_d   = ST_DRAIN;
                        ifg_cnt_d = IFG_FULL_C;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_ONE_C;
                end
            end

            ST_DRAIN: begin
                // Gap keeps counting while the rest of the frame is discarded.
                if (ifg_cnt_q < IFG_FULL_C) begin
                    ifg_cnt_d = ifg_cnt_q + IFG_ONE_C;
                end else begin
                    ifg_cnt_d = ifg_cnt_q;
                end
                if (i_valid && i_last) begin
                    trunc_flag_d = 1'b0;
                    if (ifg_cnt_q >= IFG_LAST_C) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IFG;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered GMII outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= 11'd0;
            pre_cnt_q    <= 3'd0;
            fcs_idx_q    <= 2'd0;
            ifg_cnt_q    <= '0;
            crc_q        <= CRC_INIT_C;
            trunc_flag_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
            tx_data_q    <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            trunc_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            pre_cnt_q    <= pre_cnt_d;
            fcs_idx_q    <= fcs_idx_d;
            ifg_cnt_q    <= ifg_cnt_d;
            crc_q        <= crc_d;
            trunc_flag_q <= trunc_flag_d;
            frame_cnt_q  <= frame_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            trunc_q      <= trunc_d;
            underrun_q   <= underrun_d;
        end
    end

    assign o_ready     = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_tx_data   = tx_data_q;
    assign o_tx_en     = tx_en_q;
    assign o_tx_er     = tx_er_q;
    assign o_trunc     = trunc_q;
    assign o_underrun  = underrun_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: instance A (MIN 60, MAX 64) and
// instance B (MIN 9) checked against hand-computed frame properties.
module tb_eth_tx_framer;

    logic        clk;
    logic        rst_n;
    bit          sel;
    logic [7:0]  d_data;
    logic        d_valid;
    logic        d_last;

    logic        a_valid, a_last, a_ready, a_tx_en, a_tx_er, a_busy, a_trunc, a_under;
    logic [7:0]  a_data, a_tx_data;
    logic [15:0] a_frame_cnt;
    logic        b_valid, b_last, b_ready, b_tx_en, b_tx_er, b_busy, b_trunc, b_under;
    logic [7:0]  b_data, b_tx_data;
    logic [15:0] b_frame_cnt;

    logic        m_ready, m_tx_en, m_tx_er, m_busy, m_trunc, m_under;
    logic [7:0]  m_tx_data;

    assign a_data  = sel ? 8'h00 : d_data;
    assign a_valid = sel ? 1'b0  : d_valid;
    assign a_last  = sel ? 1'b0  : d_last;
    assign b_data  = sel ? d_data  : 8'h00;
    assign b_valid = sel ? d_valid : 1'b0;
    assign b_last  = sel ? d_last  : 1'b0;

    assign m_ready   = sel ? b_ready   : a_ready;
    assign m_tx_en   = sel ? b_tx_en   : a_tx_en;
    assign m_tx_er   = sel ? b_tx_er   : a_tx_er;
    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_trunc   = sel ? b_trunc   : a_trunc;
    assign m_under   = sel ? b_under   : a_under;
    assign m_tx_data = sel ? b_tx_data : a_tx_data;

    eth_tx_framer #(.MIN_LEN(60), .MAX_LEN(64), .IFG_LEN(12)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_data(a_data), .i_valid(a_valid), .i_last(a_last),
        .o_ready(a_ready), .o_tx_data(a_tx_data), .o_tx_en(a_tx_en), .o_tx_er(a_tx_er),
        .o_busy(a_busy), .o_trunc(a_trunc), .o_underrun(a_under), .o_frame_cnt(a_frame_cnt)
    );

    eth_tx_framer #(.MIN_LEN(9), .MAX_LEN(1514), .IFG_LEN(12)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_data(b_data), .i_valid(b_valid), .i_last(b_last),
        .o_ready(b_ready), .o_tx_data(b_tx_data), .o_tx_en(b_tx_en), .o_tx_er(b_tx_er),
        .o_busy(b_busy), .o_trunc(b_trunc), .o_underrun(b_under), .o_frame_cnt(b_frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] body [0:127];
    logic [7:0] cap_q [$];
    int cyc = 0;
    int en_cnt, er_cnt, tr_cnt, un_cnt, gap_last, idle_run, first_en, first_rdy, start_cyc;
    bit seen_en;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (m_tx_en) begin
            cap_q.push_back(m_tx_data);
            en_cnt++;
            if (seen_en && idle_run > 0) gap_last = idle_run;
            idle_run = 0;
            seen_en = 1'b1;
            if (first_en < 0) first_en = cyc;
        end else if (seen_en) begin
            idle_run++;
        end
        if (m_tx_er) er_cnt++;
        if (m_trunc) tr_cnt++;
        if (m_under) un_cnt++;
        if (m_ready && first_rdy < 0) first_rdy = cyc;
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        cap_q.delete();
        en_cnt = 0; er_cnt = 0; tr_cnt = 0; un_cnt = 0;
        gap_last = 0; idle_run = 0; seen_en = 1'b0;
        first_en = -1; first_rdy = -1; start_cyc = -1;
    endtask

    task automatic send_frame(input int n, input int drop_after, input bit hold);
        int  acc;
        int  waited;
        bit  rdy;
        bit  done;
        bit  tmo;
        acc = 0;
        tmo = 1'b0;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            done   = 1'b0;
            while (!done) begin
                @(negedge clk);
                d_data  = body[i];
                d_valid = 1'b1;
                d_last  = (i == n - 1);
                if (start_cyc < 0) start_cyc = cyc;
                rdy = m_ready;
                @(posedge clk);
                if (rdy) begin
                    done = 1'b1;
                    acc++;
                end else begin
                    waited++;
                    if (waited > 400) begin
                        done = 1'b1;
                        tmo  = 1'b1;
                    end
                end
            end
            if (tmo) break;
            if (acc == drop_after) begin
                @(negedge clk);
                d_valid = 1'b0;
                d_last  = 1'b0;
                @(posedge clk);
            end
        end
        @(negedge clk);
        d_last = 1'b0;
        if (!hold) d_valid = 1'b0;
        check("beats_accepted", 32'(acc), 32'(n));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (m_busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("busy_clear", 32'(m_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] residue(input int from, input int to);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int k = from; k <= to; k++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ cap_q[k][b]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic int count_nonzero(input int from, input int to);
        int m;
        m = 0;
        for (int k = from; k <= to; k++) begin
            if (cap_q[k] !== 8'h00) m++;
        end
        return m;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        rst_n = 1'b0;
        sel = 1'b0; d_data = 8'h00; d_valid = 1'b0; d_last = 1'b0;
        en_cnt = 0; er_cnt = 0; tr_cnt = 0; un_cnt = 0; gap_last = 0; idle_run = 0;
        seen_en = 1'b0; first_en = -1; first_rdy = -1; start_cyc = -1;
        #12;
        check("rst_tx_data", 32'(a_tx_data), 32'h00);
        check("rst_tx_en", 32'(a_tx_en), 32'd0);
        check("rst_tx_er", 32'(a_tx_er), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_pulses", 32'({a_trunc, a_under}), 32'd0);
        check("rst_frame_cnt", 32'(a_frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 60-byte body 0x00..0x3B: no pad, 72 TX_EN cycles
        for (int i = 0; i < 60; i++) body[i] = 8'(i);
        clear_mon();
        send_frame(60, -1, 1'b0);
        wait_idle();
        check("t60_en_cycles", 32'(en_cnt), 32'd72);
        check("t60_first_en_latency", 32'(first_en - start_cyc), 32'd1);
        check("t60_first_ready_latency", 32'(first_rdy - start_cyc), 32'd8);
        mism = 0;
        for (int k = 0; k < 7; k++) if (cap_q[k] !== 8'h55) mism++;
        check("t60_preamble", 32'(mism), 32'd0);
        check("t60_sfd", 32'(cap_q[7]), 32'hD5);
        mism = 0;
        for (int k = 0; k < 60; k++) if (cap_q[8 + k] !== 8'(k)) mism++;
        check("t60_body", 32'(mism), 32'd0);
        check("t60_residue", residue(8, 71), 32'hDEBB_20E3);
        check("t60_frame_cnt", 32'(a_frame_cnt), 32'd1);
        check("t60_flags", 32'(er_cnt + tr_cnt + un_cnt), 32'd0);

        // 42-byte ARP body: 18 pad bytes then FCS
        for (int i = 0; i < 42; i++) body[i] = 8'((i * 7) + 3);
        clear_mon();
        send_frame(42, -1, 1'b0);
        wait_idle();
        check("arp_en_cycles", 32'(en_cnt), 32'd72);
        check("arp_last_body", 32'(cap_q[49]), 32'(8'((41 * 7) + 3)));
        check("arp_pad_zero", 32'(count_nonzero(50, 67)), 32'd0);
        check("arp_residue", residue(8, 71), 32'hDEBB_20E3);
        check("arp_frame_cnt", 32'(a_frame_cnt), 32'd2);

        // underrun after 20 bytes of a 30-byte body
        for (int i = 0; i < 30; i++) body[i] = 8'(8'hA0 + i);
        clear_mon();
        send_frame(30, 20, 1'b0);
        wait_idle();
        check("und_en_cycles", 32'(en_cnt), 32'd29);
        check("und_er_cycles", 32'(er_cnt), 32'd1);
        check("und_pulse", 32'(un_cnt), 32'd1);
        check("und_no_trunc", 32'(tr_cnt), 32'd0);
        check("und_frame_cnt", 32'(a_frame_cnt), 32'd2);

        // 100-byte body against MAX 64: truncate, FCS, drain 36
        for (int i = 0; i < 100; i++) body[i] = 8'(8'hFF - i);
        clear_mon();
        send_frame(100, -1, 1'b0);
        wait_idle();
        check("trunc_en_cycles", 32'(en_cnt), 32'd76);
        check("trunc_pulse", 32'(tr_cnt), 32'd1);
        check("trunc_residue", residue(8, 75), 32'hDEBB_20E3);
        check("trunc_frame_cnt", 32'(a_frame_cnt), 32'd2);
        check("trunc_no_er", 32'(er_cnt + un_cnt), 32'd0);

        // i_last together with count reaching MAX: normal end
        for (int i = 0; i < 64; i++) body[i] = 8'(i * 3);
        clear_mon();
        send_frame(64, -1, 1'b0);
        wait_idle();
        check("max_en_cycles", 32'(en_cnt), 32'd76);
        check("max_no_trunc", 32'(tr_cnt), 32'd0);
        check("max_residue", residue(8, 75), 32'hDEBB_20E3);
        check("max_frame_cnt", 32'(a_frame_cnt), 32'd3);

        // single-byte body: 59 pad bytes
        body[0] = 8'h5A;
        clear_mon();
        send_frame(1, -1, 1'b0);
        wait_idle();
        check("one_en_cycles", 32'(en_cnt), 32'd72);
        check("one_body", 32'(cap_q[8]), 32'h5A);
        check("one_pad_zero", 32'(count_nonzero(9, 67)), 32'd0);
        check("one_residue", residue(8, 71), 32'hDEBB_20E3);
        check("one_frame_cnt", 32'(a_frame_cnt), 32'd4);

        // back-to-back 60-byte frames with i_valid held high
        for (int i = 0; i < 60; i++) body[i] = 8'(8'h10 + i);
        clear_mon();
        send_frame(60, -1, 1'b1);
        send_frame(60, -1, 1'b0);
        wait_idle();
        check("b2b_en_cycles", 32'(en_cnt), 32'd144);
        check("b2b_gap", 32'(gap_last), 32'd12);
        check("b2b_frame_cnt", 32'(a_frame_cnt), 32'd6);
        check("b2b_no_underrun", 32'(un_cnt), 32'd0);

        // MIN 9 instance, body "123456789": FCS 26 39 F4 CB
        sel = 1'b1;
        for (int i = 0; i < 9; i++) body[i] = 8'(8'h31 + i);
        clear_mon();
        send_frame(9, -1, 1'b0);
        wait_idle();
        check("crc9_en_cycles", 32'(en_cnt), 32'd21);
        check("crc9_fcs", {cap_q[17], cap_q[18], cap_q[19], cap_q[20]}, 32'h2639_F4CB);
        check("crc9_frame_cnt", 32'(b_frame_cnt), 32'd1);
        sel = 1'b0;

        // reset asserted mid-preamble
        @(negedge clk);
        d_data = 8'h00;
        d_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_tx_en", 32'(a_tx_en), 32'd1);
        check("pre_tx_data", 32'(a_tx_data), 32'h55);
        #2;
        rst_n = 1'b0;
        d_valid = 1'b0;
        #1;
        check("rst_mid_tx_en", 32'(a_tx_en), 32'd0);
        check("rst_mid_tx_data", 32'(a_tx_data), 32'h00);
        check("rst_mid_busy", 32'(a_busy), 32'd0);
        check("rst_mid_frame_cnt", 32'(a_frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'({a_tx_en, a_busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
